// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the block engine arbiter: channel id type, block
// width and the round-robin grant helper.
// ----------------------------------------------------------------------------
package arb_pkg;

    localparam int CH_W    = 1;
    localparam int BLOCK_W = 128;

    typedef logic [CH_W-1:0] ch_t;

    localparam ch_t CH0 = 1'b0;
    localparam ch_t CH1 = 1'b1;

    // Round-robin choice between two requesters. With both requesting, the
    // channel that did not win last time gets the grant. With nobody
    // requesting the result is a don't-care; the same rule is applied so the
    // function has no special case.
    function automatic ch_t rr_grant(input logic [1:0] valid, input ch_t last);
        ch_t g;
        case (valid)
            2'b01:   g = CH0;
            2'b10:   g = CH1;
            2'b11:   g = ~last;
            default: g = ~last;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/block_engine_arbiter_tag_fifo.sv
// ----------------------------------------------------------------------------
// tag_fifo
// DEPTH x 1-bit synchronous FIFO holding the issuing channel of every block
// currently inside the engine. Pointers wrap modulo DEPTH (DEPTH = 2**AW).
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears all tags)
//   push       write push_tag at the tail (ignored when full)
//   push_tag   channel id to record
//   pop        drop the head entry (ignored when empty)
//   head       channel id at the head of the FIFO
//   count      number of stored tags (0..DEPTH)
//   full       count == DEPTH
//   empty      count == 0
// ----------------------------------------------------------------------------
module tag_fifo
    import arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  ch_t         push_tag,
    input  logic        pop,
    output ch_t         head,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZER = (AW+1)'(0);

    ch_t           mem_r [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests against the current occupancy and expose the flags.
    always_comb begin
        full      = (count_r == CNT_MAX);
        empty     = (count_r == CNT_ZER);
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        head      = mem_r[rd_ptr_r];
        count     = count_r;
    end

    // Storage, pointers and occupancy; a simultaneous push and pop leaves the
    // count unchanged while both pointers advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CNT_ZER;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= CH0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_tag;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/block_engine_arbiter.sv
// ----------------------------------------------------------------------------
// block_engine_arbiter
// Shares one 128-bit block engine between two block channels. Blocks are
// issued round-robin; a tag FIFO remembers which channel issued each block so
// that the in-order engine results are routed back to their owner.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid[1:0], in_ready[1:0]   per-channel input handshake
//   in_block0, in_block1           per-channel input blocks
//   out_valid[1:0], out_ready[1:0] per-channel result handshake
//   out_block                      shared result bus (qualify with out_valid)
//   eng_in_valid/ready/block       issue interface to the engine
//   eng_out_valid/ready/block      result interface from the engine
//   outstanding                    blocks in flight inside the engine
//   idle                           nothing in flight and nothing requested
//   err                            sticky: engine returned an untagged result
// ----------------------------------------------------------------------------
module block_engine_arbiter
    import arb_pkg::*;
#(
    parameter int TAG_DEPTH = 4,
    parameter int TAG_AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         in_valid,
    output logic [1:0]         in_ready,
    input  logic [BLOCK_W-1:0] in_block0,
    input  logic [BLOCK_W-1:0] in_block1,
    output logic [1:0]         out_valid,
    input  logic [1:0]         out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               eng_in_valid,
    input  logic               eng_in_ready,
    output logic [BLOCK_W-1:0] eng_in_block,
    input  logic               eng_out_valid,
    output logic               eng_out_ready,
    input  logic [BLOCK_W-1:0] eng_out_block,
    output logic [TAG_AW:0]    outstanding,
    output logic               idle,
    output logic               err
);

    localparam logic [TAG_AW:0] CNT_ZER = (TAG_AW+1)'(0);

    ch_t             last_grant_r;
    logic            err_r;
    ch_t             grant_s;
    ch_t             head_s;
    logic            tag_full_s;
    logic            tag_empty_s;
    logic            issue_s;
    logic            ret_s;
    logic [TAG_AW:0] count_s;

    tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .AW    (TAG_AW)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (issue_s),
        .push_tag (grant_s),
        .pop      (ret_s),
        .head     (head_s),
        .count    (count_s),
        .full     (tag_full_s),
        .empty    (tag_empty_s)
    );

    // Issue path. tag_full comes from the registered count, so a pop in the
    // same cycle never opens the issue side (no ready-to-ready path).
    // in_ready is additionally qualified by in_valid so that an idle channel
    // never sees a stray ready.
    always_comb begin
        grant_s      = rr_grant(in_valid, last_grant_r);
        eng_in_valid = (|in_valid) & ~tag_full_s;
        if (grant_s == CH1) begin
            eng_in_block = in_block1;
        end else begin
            eng_in_block = in_block0;
        end
        in_ready    = 2'b00;
        in_ready[0] = in_valid[0] & (grant_s == CH0) & eng_in_ready & ~tag_full_s;
        in_ready[1] = in_valid[1] & (grant_s == CH1) & eng_in_ready & ~tag_full_s;
        issue_s     = eng_in_valid & eng_in_ready;
    end

    // Return path. The head tag steers the result; a stalled owner stalls the
    // engine for both channels because results must leave in issue order.
    always_comb begin
        out_valid     = 2'b00;
        out_valid[0]  = eng_out_valid & ~tag_empty_s & (head_s == CH0);
        out_valid[1]  = eng_out_valid & ~tag_empty_s & (head_s == CH1);
        eng_out_ready = ~tag_empty_s & out_ready[head_s];
        ret_s         = eng_out_valid & eng_out_ready;
        out_block     = eng_out_block;
    end

    // Status outputs.
    always_comb begin
        outstanding = count_s;
        idle        = (count_s == CNT_ZER) & (in_valid == 2'b00);
        err         = err_r;
    end

    // Round-robin history and sticky protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= CH1;
            err_r        <= 1'b0;
        end else begin
            if (issue_s) begin
                last_grant_r <= grant_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
            if (eng_out_valid & tag_empty_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule

// File: doc/block_engine_arbiter.md
Name: block_engine_arbiter

Overview:
- Shares one 128-bit block engine (cipher core) between two block channels.
- Each input channel is fed by a 4-word-to-block adapter; each output channel drains into a block-to-4-word adapter.
- Round-robin issue into the engine; results return to the channel that issued them.
- A tag FIFO records the issuing channel of every outstanding block; the engine must return results in issue order.

Parameters:
- TAG_DEPTH, 4, maximum blocks in flight inside the engine; power of two, ≥2.
- TAG_AW, 2, log2(TAG_DEPTH); width of the tag FIFO pointers.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  2  per-channel block valid; bit c = channel c.
- in_ready  out  2  per-channel block accepted.
- in_block0  in  128  channel 0 input block.
- in_block1  in  128  channel 1 input block.
- out_valid  out  2  per-channel result valid.
- out_ready  in  2  per-channel result accepted.
- out_block  out  128  result block, shared by both channels; qualify with out_valid.
- eng_in_valid  out  1  block offered to engine.
- eng_in_ready  in  1  engine accepts.
- eng_in_block  out  128  block to engine.
- eng_out_valid  in  1  engine result valid.
- eng_out_ready  out  1  result consumed.
- eng_out_block  in  128  engine result.
- outstanding  out  TAG_AW+1  blocks currently in flight.
- idle  out  1  outstanding==0 and in_valid==0.
- err  out  1  sticky: engine returned a result with no tag outstanding.

Behaviour:
- Reset values:
  - Tag FIFO empty; outstanding=0; last_grant=1, so channel 0 wins first.
  - err=0; all valid and ready outputs 0.
- Reset is asynchronous and may assert mid-operation. All in-flight tags are discarded. The engine shares rst and must flush too.
- Issue path (combinational, 0-cycle latency):
  - tag_full = (outstanding==TAG_DEPTH).
  - Grant g: if exactly one in_valid bit is set, that channel; if both are set, channel !last_grant.
  - eng_in_valid = |in_valid & !tag_full.
  - eng_in_block = in_block selected by g.
  - in_ready[c] = (g==c) & eng_in_ready & !tag_full.
- Issue event: eng_in_valid & eng_in_ready. On an issue event, push g into the tag FIFO and set last_grant <= g. Otherwise last_grant holds.
- tag_full is computed from the registered count. A pop in the same cycle does NOT unblock an issue; there is no ready-to-ready combinational path.
- Return path (combinational):
  - head = tag FIFO head; tag_empty = (outstanding==0).
  - out_valid[c] = eng_out_valid & !tag_empty & (head==c).
  - out_block = eng_out_block.
  - eng_out_ready = !tag_empty & out_ready[head].
- Return event: eng_out_valid & eng_out_ready. On a return event, pop the tag FIFO.
- A backpressured output channel stalls the engine result path for both channels. Strict in-order return is intended; no reordering.
- Count update:
  - Push only: outstanding +1.
  - Pop only: outstanding -1.
  - Push and pop in the same cycle: unchanged; write and read pointers both advance.
  - Pointers are TAG_AW bits and wrap modulo TAG_DEPTH.
- Error case: eng_out_valid while tag_empty.
  - eng_out_ready=0 and no out_valid is driven.
  - err sets on that clock edge and holds until rst.
- Holding rules:
  - in_block is sampled only on an issue event; upstream must hold it while in_valid is set.
  - A grant may change between cycles while eng_in_ready is low, because round-robin is evaluated every cycle. An un-accepted offer is not a commitment.

Decomposition:
- Shared package arb_pkg: CH_W=1, BLOCK_W=128, channel-id typedef ch_t.
- One natural sub-module: tag_fifo. It is a DEPTH×1-bit synchronous FIFO with count, full/empty flags and async reset; the arbiter instantiates it once.
- The grant logic stays inline.

Test Plan:
- Single-channel flow: channel 0 sends blocks 0x…01, 0x…02; engine has 1-cycle latency; out_ready=2'b11 → out_valid[0] pulses twice with the same data; in_ready[1] is never set; err=0.
- Fairness: both channels hold in_valid for 6 issues with eng_in_ready=1 → issue order is ch0, ch1, ch0, ch1, ch0, ch1; results are routed back in that order.
- Full: eng_out_valid=0; 4 issues accepted → outstanding=4; eng_in_valid=0 and in_ready=0. Return one result → the next cycle issues again; outstanding stays 4 on a simultaneous push/pop.
- Backpressure: head tag = ch1, out_ready[1]=0, eng_out_valid=1 → eng_out_ready=0 and out_valid[1]=1 is held. Raise out_ready[1] → one pop; outstanding decrements.
- Protocol error and reset: eng_out_valid=1 with tag FIFO empty → err=1 next cycle and stays set. Assert rst mid-stream with 3 outstanding → outstanding=0, err=0, last_grant=1 immediately.
